// File: rtl/chip_checker_pkg.sv
// Shared register map, bit positions and timestamp width for the keycode capture port.
package chip_checker_pkg;
  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_FIFO  = 2'd1;
  localparam logic [1:0] ADDR_CTRL  = 2'd2;
  localparam logic [1:0] ADDR_FLUSH = 2'd3;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_OVF    = 1;
  localparam int FIFO_VALID  = 31;

  localparam int TS_W = 16;
endpackage

// File: rtl/chip_checker_sync_fifo.sv
// Small synchronous FIFO with combinational head; pop-while-full makes room for a same-cycle push.
module chip_checker_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/chip_checker_keycode_capture.sv
// Avalon-MM input port: synchronizes in_port, queues every value change, irq while pending.
// Optional CHIP_CHECKER_KEYCODE_TIMESTAMP_EN stores a 16-bit cycle stamp with each entry.
module chip_checker_keycode_capture
  import chip_checker_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [DATA_W-1:0] in_port,
  output logic [31:0]       readdata,
  output logic              irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef CHIP_CHECKER_KEYCODE_TIMESTAMP_EN
  localparam int EW = DATA_W + TS_W;
`else
  localparam int EW = DATA_W;
`endif

  logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q;
  logic [DATA_W-1:0] in_sync, prev_q;
  logic              irq_en_q, ovf_q;
  logic              change, rd_fifo, wr_ctrl, wr_flush, ovf_set;
  logic [EW-1:0]     fifo_wdata, fifo_rdata;
  logic [TS_W-1:0]   head_ts;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [29:0]       unused_wdata;

  assign in_sync  = sync_q[SYNC_STAGES-1];
  assign change   = (in_sync != prev_q);
  assign rd_fifo  = chipselect & ~read_n & (address == ADDR_FIFO);
  assign wr_ctrl  = chipselect & ~write_n & (address == ADDR_CTRL);
  assign wr_flush = chipselect & ~write_n & (address == ADDR_FLUSH);
  // A full FIFO only drops when no pop frees a slot; flush discards silently.
  assign ovf_set  = change & fifo_full & ~rd_fifo & ~wr_flush;
  assign unused_wdata = writedata[31:2];

`ifdef CHIP_CHECKER_KEYCODE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + 1'b1;
  end
  assign fifo_wdata = {ts_q, in_sync};
  assign head_ts    = fifo_rdata[EW-1:DATA_W];
`else
  assign fifo_wdata = in_sync;
  assign head_ts    = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      prev_q   <= '0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q <= in_sync;
      if (wr_ctrl) irq_en_q <= writedata[CTRL_IRQ_EN];
      if (ovf_set)                         ovf_q <= 1'b1;
      else if (wr_ctrl && writedata[CTRL_OVF]) ovf_q <= 1'b0;
    end
  end

  chip_checker_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (change),
    .pop   (rd_fifo),
    .flush (wr_flush),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[DATA_W-1:0] = in_sync;
      ADDR_FIFO: if (!fifo_empty) begin
        readdata[FIFO_VALID]   = 1'b1;
        readdata[23:8]         = head_ts;
        readdata[DATA_W-1:0]   = fifo_rdata[DATA_W-1:0];
      end
      ADDR_CTRL: begin
        readdata[15:8]        = 8'(fifo_count);
        readdata[CTRL_OVF]    = ovf_q;
        readdata[CTRL_IRQ_EN] = irq_en_q;
      end
      default: readdata = '0;
    endcase
  end

  assign irq = irq_en_q & (~fifo_empty | ovf_q);
endmodule

// File: tb/tb_chip_checker_keycode_capture.sv
// Directed bench with a queue-based reference model compared every cycle.
module tb_chip_checker_keycode_capture;
  localparam int DW = 8, DEPTH = 4, SS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0, read_n = 1'b1, write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [DW-1:0] in_port = '0;
  logic [31:0] readdata;
  logic        irq;

  always #5 clk = ~clk;

  chip_checker_keycode_capture #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(readdata), .irq(irq)
  );

  // Reference model: the value the port currently shows, the list of queued events, status bits.
  logic [DW-1:0] sh_m [SS];
  logic [DW-1:0] prev_m;
  logic [23:0]   q_m [$];
  logic          ovf_m, ien_m;
  logic [15:0]   ts_m;
  int tests = 0, fails = 0;

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r = 32'(sh_m[SS-1]);
      2'd1: if (q_m.size() > 0) r = {1'b1, 7'b0, q_m[0]};
      2'd2: r = {16'b0, 8'(q_m.size()), 6'b0, ovf_m, ien_m};
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_edge();
    logic [DW-1:0] ins;
    bit ch, pop, fl, wc, full, oset;
    logic [15:0] stamp;
    ins  = sh_m[SS-1];
    ch   = (ins != prev_m);
    pop  = chipselect && !read_n && address == 2'd1 && q_m.size() > 0;
    wc   = chipselect && !write_n && address == 2'd2;
    fl   = chipselect && !write_n && address == 2'd3;
    full = (q_m.size() == DEPTH);
    oset = 0;
`ifdef CHIP_CHECKER_KEYCODE_TIMESTAMP_EN
    stamp = ts_m;
`else
    stamp = 16'h0;
`endif
    if (reset) begin
      for (int i = 0; i < SS; i++) sh_m[i] = '0;
      prev_m = '0; q_m.delete(); ovf_m = 0; ien_m = 0; ts_m = 0;
      return;
    end
    if (fl) q_m.delete();
    else begin
      if (pop) void'(q_m.pop_front());
      if (ch) begin
        if (!full || pop) q_m.push_back({stamp, 8'(ins)});
        else oset = 1;
      end
    end
    if (wc) ien_m = writedata[0];
    if (oset) ovf_m = 1;
    else if (wc && writedata[1]) ovf_m = 0;
    ts_m = ts_m + 16'h1;
    prev_m = ins;
    for (int i = SS-1; i > 0; i--) sh_m[i] = sh_m[i-1];
    sh_m[0] = in_port;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // One clock: model advances with the DUT, then outputs are compared at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("cyc_readdata", readdata, exp_rd(address));
    check("cyc_irq", 32'(irq), 32'(ien_m && (q_m.size() > 0 || ovf_m)));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] mask,
                          input logic [31:0] exp);
    chipselect = 1; read_n = 0; address = a;
    #1;
    check(name, readdata & mask, exp);
    step();
    chipselect = 0; read_n = 1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    step();
    chipselect = 0; write_n = 1; writedata = '0;
  endtask

  task automatic change(input logic [DW-1:0] v);
    in_port = v;
    steps(3);
  endtask

  localparam logic [31:0] NOTS = 32'hFF0000FF;
  localparam logic [31:0] ALL  = 32'hFFFFFFFF;

  initial begin
    int guard;
    for (int i = 0; i < SS; i++) sh_m[i] = '0;
    prev_m = '0; ovf_m = 0; ien_m = 0; ts_m = 0;

    // 1: reset and quiet input
    steps(2);
    reset = 0;
    steps(20);
    rd_check("t1_data", 2'd0, ALL, 32'h0);
    rd_check("t1_fifo", 2'd1, ALL, 32'h0);
    rd_check("t1_ctrl", 2'd2, ALL, 32'h0);
    check("t1_irq", 32'(irq), 32'h0);

    // 2: single event, latency and pop
    wr(2'd2, 32'h1);
    in_port = 8'h1C;
    steps(2);
    check("t2_irq_early", 32'(irq), 32'h0);
    step();
    check("t2_irq_set", 32'(irq), 32'h1);
    rd_check("t2_data", 2'd0, ALL, 32'h0000_001C);
    rd_check("t2_pop", 2'd1, NOTS, 32'h8000_001C);
    rd_check("t2_empty", 2'd1, ALL, 32'h0);
    check("t2_irq_clr", 32'(irq), 32'h0);

    // 3: overflow after five events into four slots
    for (int v = 1; v <= 5; v++) change(8'(v));
    rd_check("t3_ctrl", 2'd2, ALL, 32'h0000_0403);
    for (int v = 1; v <= 4; v++) rd_check("t3_order", 2'd1, NOTS, 32'h8000_0000 | 32'(v));
    wr(2'd2, 32'h3);
    rd_check("t3_ovf_clr", 2'd2, ALL, 32'h0000_0001);
    check("t3_irq", 32'(irq), 32'h0);

    // 4: full FIFO, pop collides with push
    for (int v = 8'h11; v <= 8'h14; v++) change(8'(v));
    in_port = 8'h2A;
    steps(2);
    rd_check("t4_pop_head", 2'd1, NOTS, 32'h8000_0011);
    rd_check("t4_ctrl", 2'd2, ALL, 32'h0000_0401);
    for (int v = 8'h12; v <= 8'h14; v++) rd_check("t4_order", 2'd1, NOTS, 32'h8000_0000 | 32'(v));
    rd_check("t4_last", 2'd1, NOTS, 32'h8000_002A);

    // 5: flush collides with push, then reset with entries queued
    for (int v = 8'h31; v <= 8'h33; v++) change(8'(v));
    in_port = 8'h34;
    steps(2);
    wr(2'd3, 32'h0);
    rd_check("t5_flush_ctrl", 2'd2, ALL, 32'h0000_0001);
    rd_check("t5_flush_fifo", 2'd1, ALL, 32'h0);
    change(8'h41);
    change(8'h42);
    rd_check("t5_two", 2'd2, ALL, 32'h0000_0201);
    reset = 1;
    step();
    reset = 0;
    check("t5_rst_ctrl", exp_rd(2'd2), 32'h0);
    address = 2'd2;
    #1;
    check("t5_rst_dut_ctrl", readdata, 32'h0);
    check("t5_rst_irq", 32'(irq), 32'h0);
    steps(5);

`ifdef CHIP_CHECKER_KEYCODE_TIMESTAMP_EN
    // 6: timestamps, including the counter wrap value
    in_port = 8'h00;
    reset = 1;
    steps(2);
    reset = 0;
    guard = 0;
    while (ts_m != 16'h000E && guard < 100) begin step(); guard++; end
    check("t6_guard0", 32'(guard < 100), 32'h1);
    in_port = 8'h55;
    steps(3);
    rd_check("t6_ts10", 2'd1, 32'h80FFFFFF, 32'h8000_1055);
    guard = 0;
    while (ts_m != 16'hFFFD && guard < 70000) begin step(); guard++; end
    check("t6_guard1", 32'(guard < 70000), 32'h1);
    in_port = 8'h66;
    steps(3);
    rd_check("t6_tsffff", 2'd1, 32'h80FFFFFF, 32'h80FF_FF66);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
